// File: rtl/rv_pkg.sv
// Shared control-path types for the RV32I core: forwarding selects, hazard FSM
// states, per-stage shadow records and the major opcodes decode classifies.
package rv_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } stage_shadow_t;

    localparam int SHADOW_W = $bits(stage_shadow_t);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    function automatic logic opc_is_load(input logic [6:0] opc);
        return opc == OPC_LOAD;
    endfunction

    function automatic logic opc_writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_JAL, OPC_JALR, OPC_OP_IMM,
            OPC_OP, OPC_LUI, OPC_AUIPC:              return 1'b1;
            OPC_STORE, OPC_BRANCH:                   return 1'b0;
            default:                                 return 1'b0;
        endcase
    endfunction

    // True when stage s will write register r that a reader actually uses; x0 never counts.
    function automatic logic shadow_writes(input stage_shadow_t s, input logic [4:0] r,
                                           input logic use_r);
        return s.valid && s.reg_write && (s.rd != 5'd0) && (s.rd == r) && use_r;
    endfunction

endpackage

// File: rtl/rv_hazard_shadow.sv
// EX/MEM/WB shadow of the hazard-relevant instruction fields.
// i_hold freezes the whole chain; i_bubble loads an empty record into EX.
module rv_hazard_shadow
    import rv_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_hold,
    input  logic                i_bubble,
    input  logic [SHADOW_W-1:0] i_id,
    output logic [SHADOW_W-1:0] o_ex,
    output logic [SHADOW_W-1:0] o_mem,
    output logic [SHADOW_W-1:0] o_wb
);

    stage_shadow_t ex_q, ex_d;
    stage_shadow_t mem_q, mem_d;
    stage_shadow_t wb_q, wb_d;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!i_hold) begin
            ex_d  = i_bubble ? stage_shadow_t'('0) : stage_shadow_t'(i_id);
            mem_d = ex_q;
            wb_d  = mem_q;
        end
    end

    // Only the qualifying bits are reset; register fields are don't-care while invalid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q.valid      <= 1'b0;
            ex_q.reg_write  <= 1'b0;
            ex_q.mem_read   <= 1'b0;
            mem_q.valid     <= 1'b0;
            mem_q.reg_write <= 1'b0;
            mem_q.mem_read  <= 1'b0;
            wb_q.valid      <= 1'b0;
            wb_q.reg_write  <= 1'b0;
            wb_q.mem_read   <= 1'b0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign o_ex  = ex_q;
    assign o_mem = mem_q;
    assign o_wb  = wb_q;

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipe: stalls, flushes, redirect and memory-wait
// sequencing and EX forwarding selects. Define RV_HAZARD_FWD_EN to enable operand forwarding.
module rv_hazard_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned REDIRECT_FLUSH_CYCLES = 1,
    parameter bit          RF_WRITE_FIRST        = 1'b1
)(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_dec_valid,
    input  logic [4:0] i_dec_rs1,
    input  logic [4:0] i_dec_rs2,
    input  logic       i_dec_use_rs1,
    input  logic       i_dec_use_rs2,
    input  logic [4:0] i_dec_rd,
    input  logic       i_dec_reg_write,
    input  logic       i_dec_mem_read,
    input  logic       i_ex_redirect,
    input  logic       i_mem_busy,
    output logic       o_fetch_stall,
    output logic       o_decode_stall,
    output logic       o_decode_flush,
    output logic       o_ex_flush,
    output logic [1:0] o_fwd_rs1_sel,
    output logic [1:0] o_fwd_rs2_sel
);

    localparam logic [2:0] FLUSH_INIT = 3'(REDIRECT_FLUSH_CYCLES);

    stage_shadow_t       id_rec, ex_s, mem_s, wb_s;
    logic [SHADOW_W-1:0] ex_raw, mem_raw, wb_raw;

    hz_state_t  state_q, state_d, saved_q, saved_d, eff_state;
    logic [2:0] cnt_q, cnt_d;

    logic     hz_ex, hz_mem, hz_wb, data_stall;
    logic     fetch_stall, decode_stall, decode_flush, ex_flush;
    fwd_sel_t fwd1, fwd2;
    logic     unused_sink;

    function automatic logic id_depends(input stage_shadow_t s, input logic dec_valid,
                                        input logic [4:0] r1, input logic u1,
                                        input logic [4:0] r2, input logic u2);
        return dec_valid && (shadow_writes(s, r1, u1) || shadow_writes(s, r2, u2));
    endfunction

    assign id_rec = '{valid:     i_dec_valid,
                      rs1:       i_dec_rs1,
                      rs2:       i_dec_rs2,
                      use1:      i_dec_use_rs1,
                      use2:      i_dec_use_rs2,
                      rd:        i_dec_rd,
                      reg_write: i_dec_reg_write,
                      mem_read:  i_dec_mem_read};

    rv_hazard_shadow u_shadow (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_hold   (i_mem_busy),
        .i_bubble (ex_flush),
        .i_id     (id_rec),
        .o_ex     (ex_raw),
        .o_mem    (mem_raw),
        .o_wb     (wb_raw)
    );

    assign ex_s  = stage_shadow_t'(ex_raw);
    assign mem_s = stage_shadow_t'(mem_raw);
    assign wb_s  = stage_shadow_t'(wb_raw);

    assign hz_ex  = id_depends(ex_s,  i_dec_valid, i_dec_rs1, i_dec_use_rs1, i_dec_rs2, i_dec_use_rs2);
    assign hz_mem = id_depends(mem_s, i_dec_valid, i_dec_rs1, i_dec_use_rs1, i_dec_rs2, i_dec_use_rs2);
    assign hz_wb  = id_depends(wb_s,  i_dec_valid, i_dec_rs1, i_dec_use_rs1, i_dec_rs2, i_dec_use_rs2);

`ifdef RV_HAZARD_FWD_EN
    function automatic fwd_sel_t fwd_pick(input logic [4:0] r, input logic use_r,
                                          input stage_shadow_t ex, input stage_shadow_t mem,
                                          input stage_shadow_t wb);
        if (!ex.valid)                    return FWD_RF;
        if (shadow_writes(mem, r, use_r)) return FWD_MEM;
        if (shadow_writes(wb, r, use_r))  return FWD_WB;
        return FWD_RF;
    endfunction

    // A load in EX cannot forward yet; everything else is covered by the bypass.
    assign data_stall = hz_ex && ex_s.mem_read;
    assign fwd1       = fwd_pick(ex_s.rs1, ex_s.use1, ex_s, mem_s, wb_s);
    assign fwd2       = fwd_pick(ex_s.rs2, ex_s.use2, ex_s, mem_s, wb_s);
`else
    assign data_stall = hz_ex || hz_mem || (!RF_WRITE_FIRST && hz_wb);
    assign fwd1       = FWD_RF;
    assign fwd2       = FWD_RF;
`endif

    assign unused_sink = ^{ex_s, mem_s, wb_s, hz_mem, hz_wb, 1'(RF_WRITE_FIRST)};

    // MEM_WAIT is transparent: once the memory is ready the saved state acts this same cycle.
    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        cnt_d        = cnt_q;
        fetch_stall  = 1'b0;
        decode_stall = 1'b0;
        decode_flush = 1'b0;
        ex_flush     = 1'b0;
        eff_state    = (state_q == MEM_WAIT) ? saved_q : state_q;

        if (i_reset) begin
            decode_flush = 1'b1;
            ex_flush     = 1'b1;
        end else if (i_mem_busy) begin
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
            state_d      = MEM_WAIT;
            saved_d      = eff_state;
        end else begin
            state_d = eff_state;
            if (i_ex_redirect) begin
                decode_flush = 1'b1;
                ex_flush     = 1'b1;
                if (REDIRECT_FLUSH_CYCLES != 0) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_INIT;
                end else begin
                    state_d = RUN;
                end
            end else if (eff_state == FLUSH) begin
                decode_flush = 1'b1;
                cnt_d        = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            end else if (data_stall) begin
                fetch_stall  = 1'b1;
                decode_stall = 1'b1;
                ex_flush     = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_fetch_stall  = fetch_stall;
    assign o_decode_stall = decode_stall;
    assign o_decode_flush = decode_flush;
    assign o_ex_flush     = ex_flush;
    assign o_fwd_rs1_sel  = i_reset ? FWD_RF : fwd1;
    assign o_fwd_rs2_sel  = i_reset ? FWD_RF : fwd2;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Directed bench for rv_hazard_ctrl: reset, load-use, RAW stalls or forwarding,
// redirect flush sequencing, memory-wait freeze and reset during a memory wait.
module tb_rv_hazard_ctrl;

`ifdef RV_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid, u1, u2, rw, mr;
    logic [4:0] rs1, rs2, rd;
    logic       redirect, busy;
    logic       fs, ds, df, ef;
    logic [1:0] f1, f2;
    logic       fs0, ds0, df0, ef0;
    logic [1:0] f10, f20;
    logic       unused_tb;

    int n_tests = 0;
    int n_fail  = 0;
    int n, n1, n0;

    always #5 clk = ~clk;

    rv_hazard_ctrl #(.REDIRECT_FLUSH_CYCLES(2), .RF_WRITE_FIRST(1'b1)) dut (
        .i_clk(clk), .i_reset(reset), .i_dec_valid(dec_valid),
        .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_use_rs1(u1), .i_dec_use_rs2(u2),
        .i_dec_rd(rd), .i_dec_reg_write(rw), .i_dec_mem_read(mr),
        .i_ex_redirect(redirect), .i_mem_busy(busy),
        .o_fetch_stall(fs), .o_decode_stall(ds), .o_decode_flush(df), .o_ex_flush(ef),
        .o_fwd_rs1_sel(f1), .o_fwd_rs2_sel(f2)
    );

    rv_hazard_ctrl #(.REDIRECT_FLUSH_CYCLES(2), .RF_WRITE_FIRST(1'b0)) dut_wf0 (
        .i_clk(clk), .i_reset(reset), .i_dec_valid(dec_valid),
        .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_use_rs1(u1), .i_dec_use_rs2(u2),
        .i_dec_rd(rd), .i_dec_reg_write(rw), .i_dec_mem_read(mr),
        .i_ex_redirect(redirect), .i_mem_busy(busy),
        .o_fetch_stall(fs0), .o_decode_stall(ds0), .o_decode_flush(df0), .o_ex_flush(ef0),
        .o_fwd_rs1_sel(f10), .o_fwd_rs2_sel(f20)
    );

    assign unused_tb = ^{ds0, df0, ef0, f10, f20};

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Control outputs packed as {decode_flush, ex_flush, fetch_stall, decode_stall}.
    function automatic logic [7:0] ctl();
        return {4'b0, df, ef, fs, ds};
    endfunction

    function automatic logic [7:0] fwd();
        return {4'b0, f1, f2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] a, input logic [4:0] b,
                          input logic ua, input logic ub, input logic [4:0] d,
                          input logic w, input logic m);
        dec_valid = v; rs1 = a; rs2 = b; u1 = ua; u2 = ub; rd = d; rw = w; mr = m;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    // Called at a negedge; counts consecutive stalled cycles, bounded.
    task automatic wait_unstall(output int cnt);
        cnt = 0;
        while (fs && cnt < 8) begin
            cnt++;
            tick();
            neg();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; busy = 1'b0;
        idle();

        // reset state
        neg();
        check_eq("rst_ctl", ctl(), 8'h0C);
        check_eq("rst_fwd", fwd(), 8'h00);
        tick();
        reset = 1'b0;
        neg();
        check_eq("post_rst_run", ctl(), 8'h00);
        drain();

        // addi x7 ; add x8,x7,x7
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        n1 = 0; n0 = 0;
        for (int i = 0; i < 5; i++) begin
            neg();
            if (i == 0) check_eq("raw_first_ctl", ctl(), FWD ? 8'h00 : 8'h07);
            if (fs)  n1++;
            if (fs0) n0++;
            tick();
        end
        check_eq("raw_stalls_wf1", 8'(n1), FWD ? 8'd0 : 8'd2);
        check_eq("raw_stalls_wf0", 8'(n0), FWD ? 8'd0 : 8'd3);
        drain();

        // lw x5 ; add x6,x5,x1
        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        neg();
        check_eq("lu_ctl", ctl(), 8'h07);
        wait_unstall(n);
        check_eq("lu_stalls", 8'(n), FWD ? 8'd1 : 8'd2);
        tick();
        idle();
        neg();
        check_eq("lu_fwd", fwd(), FWD ? 8'h04 : 8'h00);
        drain();

        // writer of x0 never creates a dependency
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        neg();
        check_eq("x0_nostall", ctl(), 8'h00);
        tick();
        idle();
        neg();
        check_eq("x0_fwd", fwd(), 8'h00);
        drain();

        // x3 written in both MEM and WB, consumer reads it on rs1
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        neg();
        wait_unstall(n);
        check_eq("dbl_stalls", 8'(n), FWD ? 8'd0 : 8'd2);
        tick();
        idle();
        neg();
        check_eq("dbl_fwd", fwd(), FWD ? 8'h08 : 8'h00);
        drain();

        // x3 in MEM only, consumer reads it on rs2
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        neg();
        wait_unstall(n);
        check_eq("mem_stalls", 8'(n), FWD ? 8'd0 : 8'd2);
        tick();
        idle();
        neg();
        check_eq("mem_fwd_rs2", fwd(), FWD ? 8'h02 : 8'h00);
        drain();

        // redirect with two extra flush cycles
        redirect = 1'b1;
        neg();
        check_eq("redir_ctl", ctl(), 8'h0C);
        tick();
        redirect = 1'b0;
        neg();
        check_eq("flush1_ctl", ctl(), 8'h08);
        tick();
        neg();
        check_eq("flush2_ctl", ctl(), 8'h08);
        tick();
        neg();
        check_eq("flush_done", ctl(), 8'h00);
        tick();

        // memory wait in the last flush cycle
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        neg();
        tick();
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            neg();
            check_eq($sformatf("busy_ctl_%0d", i), ctl(), 8'h03);
            tick();
        end
        busy = 1'b0;
        neg();
        check_eq("post_busy_flush", ctl(), 8'h08);
        tick();
        neg();
        check_eq("post_busy_run", ctl(), 8'h00);
        drain();

        // shadows hold across a memory wait
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            neg();
            check_eq($sformatf("freeze_ctl_%0d", i), ctl(), 8'h03);
            tick();
        end
        busy = 1'b0;
        neg();
        check_eq("thaw_ctl", ctl(), FWD ? 8'h00 : 8'h07);
        wait_unstall(n);
        check_eq("thaw_stalls", 8'(n), FWD ? 8'd0 : 8'd2);
        tick();
        idle();
        neg();
        check_eq("thaw_fwd", fwd(), FWD ? 8'h08 : 8'h00);
        drain();

        // reset while waiting on memory
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        idle();
        busy = 1'b1;
        neg();
        check_eq("pre_rst_wait", ctl(), 8'h03);
        tick();
        reset = 1'b1;
        neg();
        check_eq("rst_wait_ctl", ctl(), 8'h0C);
        check_eq("rst_wait_fwd", fwd(), 8'h00);
        tick();
        reset = 1'b0;
        busy  = 1'b0;
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        neg();
        check_eq("rst_run_ctl", ctl(), 8'h00);
        tick();
        idle();
        neg();
        check_eq("rst_run_fwd", fwd(), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
